// File: rtl/pid_pwm_driver_pkg.sv
// Shared defaults, channel state encoding and width helper for the PID-driven PWM bridge driver.
package pid_pwm_driver_pkg;

  localparam int unsigned PWM_PERIOD_DEF  = 1000;
  localparam int unsigned DEADTIME_DEF    = 50;
  localparam int unsigned WDOG_FRAMES_DEF = 100;

  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StRev,
    StDead
  } chn_state_e;

  // Counter must hold PWM_PERIOD itself so a full-scale magnitude means 100% duty.
  function automatic int unsigned cnt_width(input int unsigned period);
    return $clog2(period + 1);
  endfunction

endpackage

// File: rtl/pid_pwm_driver_chn.sv
// One motor channel: shadow/active duty, direction FSM with dead time, watchdog and registered
// bridge outputs.
module pwm_chn_fsm
  import pid_pwm_driver_pkg::*;
#(
  parameter int unsigned PWM_PERIOD  = PWM_PERIOD_DEF,
  parameter int unsigned DEADTIME    = DEADTIME_DEF,
  parameter int unsigned WDOG_FRAMES = WDOG_FRAMES_DEF,
  parameter int unsigned CNT_WIDTH   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic                 wrap_i,
  input  logic                 wr_i,
  input  logic                 wr_dir_i,
  input  logic [CNT_WIDTH-1:0] wr_mag_i,
  input  logic                 stop_i,
  output logic                 in1_o,
  output logic                 in2_o
);

  localparam int unsigned WW = $clog2(WDOG_FRAMES + 1);

  chn_state_e           state_q, state_d;
  logic                 shadow_dir_q, shadow_dir_d, act_dir_q, act_dir_d;
  logic [CNT_WIDTH-1:0] shadow_mag_q, shadow_mag_d, act_mag_q, act_mag_d;
  logic [WW-1:0]        wdog_q, wdog_d;
  logic                 in1_q, in1_d, in2_q, in2_d;
  logic                 duty_on, expire;

  always_comb begin
    state_d      = state_q;
    shadow_dir_d = shadow_dir_q;
    shadow_mag_d = shadow_mag_q;
    act_dir_d    = act_dir_q;
    act_mag_d    = act_mag_q;
    wdog_d       = wdog_q;
    in1_d        = 1'b0;
    in2_d        = 1'b0;
    duty_on      = cnt_i < act_mag_q;
    expire       = !wr_i && wrap_i && (wdog_q >= WW'(WDOG_FRAMES - 1));

    if (wr_i) begin
      shadow_dir_d = wr_dir_i;
      shadow_mag_d = wr_mag_i;
      wdog_d       = '0;
    end else if (wrap_i && (wdog_q < WW'(WDOG_FRAMES))) begin
      wdog_d = wdog_q + 1'b1;
    end

    unique case (state_q)
      StIdle: ;
      StFwd:  in1_d = duty_on;
      StRev:  in2_d = duty_on;
      // Dead time is measured on the shared counter since it always starts at frame start.
      StDead: if (cnt_i == CNT_WIDTH'(DEADTIME - 1)) state_d = act_dir_q ? StRev : StFwd;
      default: state_d = StIdle;
    endcase

    if (wrap_i) begin
      act_mag_d = shadow_mag_q;
      act_dir_d = shadow_dir_q;
      if (shadow_mag_q == '0) begin
        state_d = StIdle;
      end else if (state_q == StIdle || shadow_dir_q == act_dir_q) begin
        state_d = shadow_dir_q ? StRev : StFwd;
      end else begin
        state_d = StDead;
      end
    end

    if (expire || stop_i) begin
      state_d      = StIdle;
      act_mag_d    = '0;
      shadow_mag_d = '0;
    end
    if (stop_i) begin
      in1_d = 1'b0;
      in2_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      shadow_dir_q <= 1'b0;
      shadow_mag_q <= '0;
      act_dir_q    <= 1'b0;
      act_mag_q    <= '0;
      wdog_q       <= '0;
      in1_q        <= 1'b0;
      in2_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_dir_q <= shadow_dir_d;
      shadow_mag_q <= shadow_mag_d;
      act_dir_q    <= act_dir_d;
      act_mag_q    <= act_mag_d;
      wdog_q       <= wdog_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
    end
  end

  assign in1_o = in1_q;
  assign in2_o = in2_q;

  a_no_shoot_through: assert property (@(posedge clk) disable iff (rst) !(in1_q && in2_q));

endmodule

// File: rtl/pid_pwm_driver.sv
// Sign-magnitude PWM driver for NUM_CHN H-bridges fed by the PID core's control stream;
// owns the shared frame counter and the control-word decode.
module pid_pwm_driver
  import pid_pwm_driver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned NUM_CHN     = 4,
  parameter int unsigned CHN_WIDTH   = 3,
  parameter int unsigned PWM_PERIOD  = PWM_PERIOD_DEF,
  parameter int unsigned DEADTIME    = DEADTIME_DEF,
  parameter int unsigned WDOG_FRAMES = WDOG_FRAMES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  u_valid_i,
  input  logic [CHN_WIDTH-1:0]  u_chn_i,
  input  logic [DATA_WIDTH-1:0] u_data_i,
  input  logic [NUM_CHN-1:0]    stop_i,
  output logic [NUM_CHN-1:0]    motor_in1_o,
  output logic [NUM_CHN-1:0]    motor_in2_o,
  output logic                  frame_o
);

  localparam int unsigned CNT_WIDTH = cnt_width(PWM_PERIOD);

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  frame_q;
  logic                  wrap;
  logic                  neg;
  logic [DATA_WIDTH-1:0] abs_u;
  logic [CNT_WIDTH-1:0]  mag;
  logic [NUM_CHN-1:0]    wr;

  assign wrap  = (cnt_q == CNT_WIDTH'(PWM_PERIOD - 1));
  assign cnt_d = wrap ? '0 : cnt_q + 1'b1;

  always_comb begin
    neg = u_data_i[DATA_WIDTH-1];
    // Most negative value has no positive twin; saturate before taking the magnitude.
    if (u_data_i == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
      abs_u = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (neg) begin
      abs_u = -u_data_i;
    end else begin
      abs_u = u_data_i;
    end
    if (abs_u > DATA_WIDTH'(PWM_PERIOD)) begin
      mag = CNT_WIDTH'(PWM_PERIOD);
    end else begin
      mag = abs_u[CNT_WIDTH-1:0];
    end
    wr = '0;
    for (int unsigned c = 0; c < NUM_CHN; c++) begin
      if (u_valid_i && (u_chn_i == CHN_WIDTH'(c)) && !stop_i[c]) wr[c] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      frame_q <= wrap;
    end
  end

  assign frame_o = frame_q;

  for (genvar g = 0; g < NUM_CHN; g++) begin : g_chn
    pwm_chn_fsm #(
      .PWM_PERIOD (PWM_PERIOD),
      .DEADTIME   (DEADTIME),
      .WDOG_FRAMES(WDOG_FRAMES),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_chn (
      .clk     (clk),
      .rst     (rst),
      .cnt_i   (cnt_q),
      .wrap_i  (wrap),
      .wr_i    (wr[g]),
      .wr_dir_i(neg),
      .wr_mag_i(mag),
      .stop_i  (stop_i[g]),
      .in1_o   (motor_in1_o[g]),
      .in2_o   (motor_in2_o[g])
    );
  end

endmodule
